// File: rtl/au_pkg.sv
// Shared definitions for the 8-bit arithmetic unit and its command sequencer:
// opcode encoding, sequencer FSM states and per-op wait counts.
package au_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_DIV = 2'b10;
  localparam logic [1:0] OP_MUL = 2'b11;

  localparam int unsigned LAT_ADDSUB = 0;
  localparam int unsigned LAT_MUL    = 1;
  localparam int unsigned DIV_BLANK  = 2;

  localparam int unsigned CNT_W = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } au_state_t;

  // Wait count loaded in ISSUE; for divide it blanks a stale done from the previous op.
  function automatic logic [CNT_W-1:0] wait_count(input logic [1:0] op);
    logic [CNT_W-1:0] cnt;
    case (op)
      OP_MUL:  cnt = CNT_W'(LAT_MUL);
      OP_DIV:  cnt = CNT_W'(DIV_BLANK);
      default: cnt = CNT_W'(LAT_ADDSUB);
    endcase
    return cnt;
  endfunction

endpackage

// File: rtl/au_cmd_sequencer.sv
// Command front-end for the arithmetic unit.
// Accepts one op over cmd_valid/cmd_ready, drives au_a/au_b/au_op (and au_start
// for divide), waits the op latency or for au_done, then returns rsp_data/rsp_err
// over rsp_valid/rsp_ready. Divide-by-zero is answered immediately with 8'hFF and
// an error; a divide without done within DIV_TIMEOUT WAIT cycles returns 0 + error.
// Ports: clk, rst (async active-low), cmd_* (request), au_* (arith unit),
//        rsp_* (response), busy (FSM not idle).
module au_cmd_sequencer
  import au_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned DIV_TIMEOUT = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  output logic [DATA_W-1:0] au_a,
  output logic [DATA_W-1:0] au_b,
  output logic [1:0]        au_op,
  output logic              au_start,
  input  logic [DATA_W-1:0] au_result,
  input  logic              au_done,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              busy
);

  localparam int unsigned TMO_W = $clog2(DIV_TIMEOUT + 1);

  au_state_t         r_state, w_state_nxt;
  logic [DATA_W-1:0] r_au_a, w_au_a_nxt;
  logic [DATA_W-1:0] r_au_b, w_au_b_nxt;
  logic [1:0]        r_au_op, w_au_op_nxt;
  logic              r_au_start, w_au_start_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [TMO_W-1:0]  r_tmo, w_tmo_nxt;
  logic [DATA_W-1:0] r_rsp_data, w_rsp_data_nxt;
  logic              r_rsp_err, w_rsp_err_nxt;
  logic              r_rsp_valid, w_rsp_valid_nxt;
  logic              r_busy, w_busy_nxt;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_au_a      <= '0;
      r_au_b      <= '0;
      r_au_op     <= '0;
      r_au_start  <= 1'b0;
      r_cnt       <= '0;
      r_tmo       <= '0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_au_a      <= w_au_a_nxt;
      r_au_b      <= w_au_b_nxt;
      r_au_op     <= w_au_op_nxt;
      r_au_start  <= w_au_start_nxt;
      r_cnt       <= w_cnt_nxt;
      r_tmo       <= w_tmo_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    w_state_nxt    = r_state;
    w_au_a_nxt     = r_au_a;
    w_au_b_nxt     = r_au_b;
    w_au_op_nxt    = r_au_op;
    w_au_start_nxt = 1'b0;
    w_cnt_nxt      = r_cnt;
    w_tmo_nxt      = r_tmo;
    w_rsp_data_nxt = r_rsp_data;
    w_rsp_err_nxt  = r_rsp_err;

    unique case (r_state)
      S_IDLE: begin
        // cmd_ready is implied here: rst is high whenever the clock advances state.
        if (cmd_valid) begin
          w_au_a_nxt  = cmd_a;
          w_au_b_nxt  = cmd_b;
          w_au_op_nxt = cmd_op;
          if ((cmd_op == OP_DIV) && (cmd_b == '0)) begin
            w_rsp_data_nxt = '1;
            w_rsp_err_nxt  = 1'b1;
            w_state_nxt    = S_RESP;
          end else begin
            // Registered so the pulse is seen during the ISSUE cycle.
            w_au_start_nxt = (cmd_op == OP_DIV);
            w_state_nxt    = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        w_cnt_nxt   = wait_count(r_au_op);
        w_tmo_nxt   = '0;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (r_au_op == OP_DIV) begin
          w_tmo_nxt = r_tmo + TMO_W'(1);
          if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
          // Done wins over a timeout landing in the same cycle.
          if ((r_cnt == '0) && au_done) begin
            w_rsp_data_nxt = au_result;
            w_rsp_err_nxt  = 1'b0;
            w_state_nxt    = S_RESP;
          end else if (r_tmo == TMO_W'(DIV_TIMEOUT - 1)) begin
            w_rsp_data_nxt = '0;
            w_rsp_err_nxt  = 1'b1;
            w_state_nxt    = S_RESP;
          end
        end else if (r_cnt == '0) begin
          w_rsp_data_nxt = au_result;
          w_rsp_err_nxt  = 1'b0;
          w_state_nxt    = S_RESP;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_rsp_valid_nxt = (w_state_nxt == S_RESP);
    w_busy_nxt      = (w_state_nxt != S_IDLE);
  end

  assign cmd_ready = (r_state == S_IDLE) & rst;
  assign au_a      = r_au_a;
  assign au_b      = r_au_b;
  assign au_op     = r_au_op;
  assign au_start  = r_au_start;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign busy      = r_busy;

endmodule

// File: tb/tb_au_cmd_sequencer.sv
// Scoreboard bench for au_cmd_sequencer with a behavioural arithmetic-unit model.
module tb_au_cmd_sequencer;
  import au_pkg::*;

  localparam int unsigned DW  = 8;
  localparam int unsigned TMO = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'b00;
  logic [DW-1:0] cmd_a = '0;
  logic [DW-1:0] cmd_b = '0;
  logic [DW-1:0] au_a, au_b;
  logic [1:0]    au_op;
  logic          au_start;
  logic [DW-1:0] au_result;
  logic          au_done;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic          busy;

  au_cmd_sequencer #(.DATA_W(DW), .DIV_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .au_a(au_a), .au_b(au_b), .au_op(au_op), .au_start(au_start),
    .au_result(au_result), .au_done(au_done),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    logic       err;
    int         lat;
    int         acc;
  } exp_t;

  typedef struct {
    int lat;
    bit hang;
  } au_job_t;

  exp_t    exp_q[$];
  au_job_t au_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int exp_start_cyc = -1;
  int last_hs_cyc   = -10;
  int hold_cnt      = 0;
  bit rdy_rand      = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: response value, error flag and accept-to-rsp_valid latency.
  function automatic void ref_rsp(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                                  input int lat, input bit hang,
                                  output logic [7:0] d, output logic e, output int l);
    int ia = int'(a);
    int ib = int'(b);
    e = 1'b0;
    case (op)
      OP_ADD: begin d = 8'((ia + ib) % 256);       l = 3; end
      OP_SUB: begin d = 8'((ia - ib + 256) % 256); l = 3; end
      OP_MUL: begin d = 8'((ia * ib) % 256);       l = 4; end
      default: begin
        if (ib == 0) begin
          d = 8'hFF; e = 1'b1; l = 1;
        end else if (hang) begin
          d = 8'h00; e = 1'b1; l = int'(TMO) + 2;
        end else begin
          // Two blanking WAIT cycles, then the first cycle done is seen.
          d = 8'(ia / ib);
          l = (lat + 3 > 5) ? lat + 3 : 5;
        end
      end
    endcase
  endfunction

  // Arithmetic unit model: combinational add/sub/mul, divide done after a job-defined
  // delay; done stays high until one cycle after the next start, so it goes stale.
  logic [7:0] div_res, div_pend;
  logic       done_r, clr_r;
  int         au_cnt;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_r   <= 1'b0;
      clr_r    <= 1'b0;
      au_cnt   <= 0;
      div_res  <= '0;
      div_pend <= '0;
    end else if (au_start) begin
      clr_r    <= 1'b1;
      div_pend <= (au_b != 0) ? au_a / au_b : 8'h00;
      if (au_q.size() > 0) begin
        au_cnt <= au_q[0].hang ? 0 : au_q[0].lat;
        void'(au_q.pop_front());
      end else begin
        au_cnt <= 0;
      end
    end else begin
      if (clr_r) begin
        clr_r  <= 1'b0;
        done_r <= 1'b0;
      end
      if (au_cnt == 1) begin
        done_r  <= 1'b1;
        div_res <= div_pend;
        au_cnt  <= 0;
      end else if (au_cnt > 1) begin
        au_cnt <= au_cnt - 1;
      end
    end
  end
  assign au_done   = done_r;
  assign au_result = (au_op == OP_DIV) ? div_res :
                     (au_op == OP_ADD) ? au_a + au_b :
                     (au_op == OP_SUB) ? au_a - au_b : au_a * au_b;

  // Response consumer.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (hold_cnt > 0) begin
        rsp_ready = 1'b0;
        if (rsp_valid) hold_cnt--;
      end else begin
        rsp_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard on each response handshake.
  initial begin
    bit         seen = 1'b0;
    logic [7:0] held_d = '0;
    logic       held_e = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        seen = 1'b0;
      end else begin
        if (au_start || (cyc == exp_start_cyc))
          chk("au_start_in_issue", 32'(au_start), 32'(cyc == exp_start_cyc));
        if (rsp_valid) begin
          chk("cmd_ready_low_in_resp", 32'(cmd_ready), 32'd0);
          chk("busy_in_resp", 32'(busy), 32'd1);
          if (!seen) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
              chk("rsp_latency", 32'(cyc - exp_q[0].acc), 32'(exp_q[0].lat));
            end
            seen   = 1'b1;
            held_d = rsp_data;
            held_e = rsp_err;
          end else begin
            chk("rsp_stable", 32'({rsp_err, rsp_data}), 32'({held_e, held_d}));
          end
          if (rsp_ready) begin
            if (exp_q.size() > 0) begin
              chk("rsp_data", 32'(rsp_data), 32'(exp_q[0].data));
              chk("rsp_err", 32'(rsp_err), 32'(exp_q[0].err));
              void'(exp_q.pop_front());
            end
            seen        = 1'b0;
            last_hs_cyc = cyc;
          end
        end
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                      input int lat, input bit hang);
    int   w = 0;
    exp_t e;
    @(negedge clk);
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    while (!cmd_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    if (w > 0) chk("throughput", 32'(cyc), 32'(last_hs_cyc + 1));
    ref_rsp(op, a, b, lat, hang, e.data, e.err, e.lat);
    e.acc = cyc;
    exp_q.push_back(e);
    if (op == OP_DIV && b != 0) begin
      au_job_t j;
      j.lat = lat;
      j.hang = hang;
      au_q.push_back(j);
      exp_start_cyc = cyc + 1;
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int w = 0;
    while ((exp_q.size() != 0 || rsp_valid) && w < 400) begin
      @(negedge clk);
      w++;
    end
    if (exp_q.size() != 0 || rsp_valid) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #1;
    chk("reset_outputs", 32'({au_a, au_b, au_op, au_start, rsp_data, rsp_err, rsp_valid, busy, cmd_ready}), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("cmd_ready_after_reset", 32'(cmd_ready), 32'd1);

    send(OP_ADD, 8'd100, 8'd27, 0, 1'b0);
    wait_idle();
    send(OP_SUB, 8'd5, 8'd9, 0, 1'b0);
    send(OP_MUL, 8'd13, 8'd11, 0, 1'b0);
    wait_idle();
    send(OP_DIV, 8'd200, 8'd7, 3, 1'b0);
    send(OP_DIV, 8'd9, 8'd3, 1, 1'b0);
    wait_idle();
    send(OP_DIV, 8'd50, 8'd0, 0, 1'b0);
    wait_idle();
    send(OP_DIV, 8'd77, 8'd5, 0, 1'b1);
    wait_idle();
    hold_cnt = 5;
    send(OP_ADD, 8'd250, 8'd9, 0, 1'b0);
    wait_idle();

    // Reset during a hung divide's WAIT: outputs clear at once, no response follows.
    send(OP_DIV, 8'd10, 8'd2, 0, 1'b1);
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("reset_mid_op", 32'({au_a, au_b, au_op, au_start, rsp_data, rsp_err, rsp_valid, busy, cmd_ready}), 32'd0);
    exp_q.delete();
    au_q.delete();
    exp_start_cyc = -1;
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("cmd_ready_after_abort", 32'(cmd_ready), 32'd1);
    repeat (40) @(negedge clk);
    chk("no_rsp_after_abort", 32'(rsp_valid), 32'd0);

    rdy_rand = 1'b1;
    for (int i = 0; i < 150; i++) begin
      logic [1:0] op;
      logic [7:0] a, b;
      bit         hang;
      op   = 2'($urandom_range(0, 3));
      a    = 8'($urandom_range(0, 255));
      b    = 8'($urandom_range(0, 255));
      hang = 1'b0;
      if (op == OP_DIV) begin
        if ($urandom_range(0, 7) == 0) b = 8'd0;
        hang = ($urandom_range(0, 15) == 0);
      end
      send(op, a, b, int'($urandom_range(1, 20)), hang);
    end
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/au_cmd_sequencer.md
Name: au_cmd_sequencer

Overview:
- Command front-end directly upstream of the 8-bit arithmetic unit (add/sub/div/mul, 2-bit op select, start, done).
- Accepts one operation at a time over a valid/ready handshake and drives the unit's operand, op-select and start inputs.
- Waits the op-specific latency, or for done on divide, then returns the result over a valid/ready response channel.
- Screens divide-by-zero and guards against a hung divide with a timeout.

Parameters:
- DATA_W, 8, operand/result width; must match the arithmetic unit.
- DIV_TIMEOUT, 32, maximum WAIT cycles for a divide before an error response is returned.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low; shared with the arithmetic unit.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_op  in  2  00 add, 01 sub, 10 div, 11 mul.
- cmd_a  in  DATA_W  operand A (dividend).
- cmd_b  in  DATA_W  operand B (divisor).
- au_a  out  DATA_W  registered operand A to the arithmetic unit.
- au_b  out  DATA_W  registered operand B to the arithmetic unit.
- au_op  out  2  registered op select to the arithmetic unit.
- au_start  out  1  one-cycle divider start pulse.
- au_result  in  DATA_W  arithmetic unit result.
- au_done  in  1  arithmetic unit done.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  DATA_W  result.
- rsp_err  out  1  divide-by-zero or timeout.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst low, async):
  - State IDLE.
  - au_a, au_b, au_op, au_start, rsp_data, rsp_err, rsp_valid, counters all 0.
  - cmd_ready = (state==IDLE) & rst, so it is 0 while reset is asserted.
  - Reset mid-operation aborts the operation; no response is produced.
- FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE. The divide-by-zero path goes IDLE -> RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid & cmd_ready at cycle T, register cmd_a/cmd_b/cmd_op into au_a/au_b/au_op. These stay stable until the next accept.
  - If cmd_op=div and cmd_b=0: rsp_data<=8'hFF, rsp_err<=1, go to RESP. au_start is never pulsed.
  - Otherwise go to ISSUE.
- ISSUE (cycle T+1):
  - au_start=1 for div only, exactly one cycle.
  - Load wait count: add/sub 0, mul 1, div 2 (blanking of a stale done).
  - Clear the timeout counter; go to WAIT.
- WAIT, add/sub/mul:
  - If count==0, capture au_result into rsp_data, rsp_err<=0, go to RESP.
  - Otherwise decrement.
  - Capture lands at T+2 (add/sub) or T+3 (mul).
- WAIT, divide:
  - Decrement the count while nonzero; au_done is ignored during this blanking.
  - Once count==0, capture au_result on au_done=1 (rsp_err<=0) and go to RESP.
  - The timeout counter increments every WAIT cycle. On reaching DIV_TIMEOUT without done: rsp_data<=0, rsp_err<=1, go to RESP.
- RESP:
  - rsp_valid=1; rsp_data/rsp_err held stable until rsp_ready.
  - On rsp_valid & rsp_ready, go to IDLE and drop rsp_valid the next cycle.
  - cmd_ready=0 throughout, so there is no overlap.
- Latency from accept to rsp_valid: add/sub 3 cycles, mul 4 cycles, div-by-zero 1 cycle, div by done timing.
- Throughput: the next command can be accepted the cycle after the response handshake.
- Width rules: all results are modulo 2^DATA_W; carries, borrows and remainders are not reported.

Decomposition:
- Shared package au_pkg:
  - opcode constants OP_ADD=2'b00, OP_SUB=2'b01, OP_DIV=2'b10, OP_MUL=2'b11;
  - FSM state encoding;
  - latency constants LAT_ADDSUB=0, LAT_MUL=1, DIV_BLANK=2.
  - The arithmetic unit's control decode uses the same package.
- No sub-module: single FSM plus datapath registers in one module.

Test Plan:
- ADD cmd_a=100, cmd_b=27, bench drives rsp_ready=1 -> rsp_data=127, rsp_err=0, rsp_valid first high 3 cycles after accept; au_start never high.
- SUB 5-9, then MUL 13*11 back-to-back -> 8'hFC, then 8'h8F with rsp_valid 4 cycles after the second accept.
- DIV 200/7 then DIV 9/3 -> 28 then 3 (not stale 28); au_start is one cycle per divide, in ISSUE only.
- DIV 50/0 -> rsp_data=8'hFF, rsp_err=1 one cycle after accept; au_start stays 0.
- DIV with au_done held 0 by the bench model -> after DIV_TIMEOUT WAIT cycles rsp_data=0, rsp_err=1; FSM returns to IDLE after rsp_ready.
- Hold rsp_ready=0 for 5 cycles -> rsp_data stable, cmd_ready=0; pulse rst low during WAIT -> all outputs 0 immediately, no response, cmd_ready=1 after release.
